// File: rtl/dmem_image_streamer.sv
// Scans the data-memory RAM from address 0 to NUM_WORDS-1 and streams the low
// byte of every word through a small capture FIFO onto a valid/ready pixel port.
module dmem_image_streamer #(
    parameter int NUM_WORDS  = 129600,
    parameter int FIFO_DEPTH = 4,
    parameter int PIXEL_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               mem_req,
    output logic [31:0]        mem_address,
    input  logic [31:0]        mem_rd,
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      LAST_ADDR = 32'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic [PIXEL_W:0]   fifo_q [FIFO_DEPTH];

    logic               push_s;
    logic               pop_s;
    logic [PIXEL_W:0]   head_s;
    logic [PIXEL_W:0]   entry_s;
    logic               unused_upper_s;

    assign unused_upper_s = ^mem_rd[31:PIXEL_W];

    // Next-state logic: scan FSM, read counter and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        push_s   = 1'b0;
        pop_s    = (count_q != CNT_W'(0)) && pix_ready;
        head_s   = fifo_q[rd_ptr_q];
        entry_s  = {(addr_q == LAST_ADDR), mem_rd[PIXEL_W-1:0]};
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = 32'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Fullness uses the registered count, so a same-cycle pop cannot free a slot.
                if (count_q < FULL_CNT) begin
                    push_s = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 32'd1;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (pop_s && head_s[PIXEL_W]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = 32'd0;
            end
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    // Capture FIFO storage: {last flag, pixel} per entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= entry_s;
        end else begin
            fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
        end
    end

    assign mem_req     = (state_q == S_READ);
    assign mem_address = mem_req ? addr_q : 32'd0;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign pix_valid   = (count_q != CNT_W'(0));
    assign pix_data    = pix_valid ? head_s[PIXEL_W-1:0] : PIXEL_W'(0);
    assign pix_last    = pix_valid ? head_s[PIXEL_W] : 1'b0;

endmodule

// File: tb/tb_dmem_image_streamer.sv
// Directed bench for dmem_image_streamer with a RAM model and an expected-pixel
// scoreboard filled at each start and drained on every output handshake.
module tb_dmem_image_streamer;

    localparam int NW = 16;
    localparam int FD = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic          mem_req, busy, done, pix_valid, pix_last;
    logic [31:0]   mem_address, mem_rd;
    logic [PW-1:0] pix_data;
    logic [31:0]   ram_base = 32'h1234_5600;
    logic [31:0]   ram_mul  = 32'd1;

    always #5 clk = ~clk;

    assign mem_rd = ram_base + mem_address * ram_mul;

    dmem_image_streamer #(.NUM_WORDS(NW), .FIFO_DEPTH(FD), .PIXEL_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_req(mem_req), .mem_address(mem_address), .mem_rd(mem_rd),
        .busy(busy), .done(done),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_cnt, done_cnt, scan_cnt, req_cnt, first_hs, last_hs, done_cyc, scan_cyc;
    logic [31:0]  max_addr;
    logic         prev_busy = 1'b0;
    logic [PW:0]  mon_e;
    logic [PW:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; done_cnt = 0; scan_cnt = 0; req_cnt = 0;
        first_hs = 0; last_hs = 0; done_cyc = 0; scan_cyc = 0; max_addr = 32'd0;
    endtask

    task automatic load_exp();
        logic [31:0] w;
        for (int k = 0; k < NW; k++) begin
            w = ram_base + 32'(k) * ram_mul;
            exp_q.push_back({(k == NW - 1), w[PW-1:0]});
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({pfx, "_mem_address"}, mem_address, 32'd0);
        chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        chk({pfx, "_done"}, {31'd0, done}, 32'd0);
        chk({pfx, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({pfx, "_pix_data"}, {24'd0, pix_data}, 32'd0);
        chk({pfx, "_pix_last"}, {31'd0, pix_last}, 32'd0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_cnt > d0) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $error("FAIL done_timeout: observed no done within %0d cycles expected a done pulse", budget);
        end
    endtask

    // Monitor: scoreboard pops on handshakes plus per-cycle output rules.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (!mem_req) chk("addr_zero_without_req", mem_address, 32'd0);
            if (!pix_valid) begin
                chk("pix_data_zero_when_invalid", {24'd0, pix_data}, 32'd0);
                chk("pix_last_zero_when_invalid", {31'd0, pix_last}, 32'd0);
            end
            if (mem_req) begin
                req_cnt++;
                if (mem_address > max_addr) max_addr = mem_address;
            end
            if (busy && !prev_busy) begin
                scan_cnt++;
                scan_cyc = cyc;
                chk("scan_first_req", {31'd0, mem_req}, 32'd1);
                chk("scan_first_addr", mem_address, 32'd0);
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel_queue_size", 32'd0, 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_data", {24'd0, pix_data}, {24'd0, mon_e[PW-1:0]});
                    chk("pix_last", {31'd0, pix_last}, {31'd0, mon_e[PW]});
                end
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_in_done_cycle", {31'd0, busy}, 32'd0);
            end
        end
        prev_busy = busy;
    end

    initial begin
        void'($urandom(32'd1234));
        clear_stats();

        // Reset while idle.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_idle");
        @(posedge clk); #1 rst_n = 1'b1;

        // Full scan with ready held high.
        clear_stats();
        load_exp();
        pix_ready = 1'b1;
        pulse_start();
        wait_done(60);
        @(negedge clk);
        chk("full_handshakes", 32'(hs_cnt), 32'd16);
        chk("full_done_count", 32'(done_cnt), 32'd1);
        chk("full_req_cycles", 32'(req_cnt), 32'd16);
        chk("full_max_addr", max_addr, 32'd15);
        chk("full_first_pixel_latency", 32'(first_hs - scan_cyc), 32'd1);
        chk("full_no_bubbles", 32'(last_hs - first_hs), 32'd15);
        chk("full_done_after_last", 32'(done_cyc - last_hs), 32'd1);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a scan.
        clear_stats();
        load_exp();
        pulse_start();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_req_next_cycle", {31'd0, mem_req}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();

        // Scan after reset restarts from address 0.
        clear_stats();
        ram_base = 32'h0000_0040;
        load_exp();
        pulse_start();
        wait_done(60);
        chk("post_rst_handshakes", 32'(hs_cnt), 32'd16);
        chk("post_rst_scans", 32'(scan_cnt), 32'd1);
        chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: ready low for ten cycles after start.
        clear_stats();
        ram_base  = 32'hABCD_EF30;
        pix_ready = 1'b0;
        load_exp();
        pulse_start();
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("bp_addr_holds", mem_address, 32'd4);
        chk("bp_req_held", {31'd0, mem_req}, 32'd1);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        chk("bp_head_valid", {31'd0, pix_valid}, 32'd1);
        chk("bp_head_data", {24'd0, pix_data}, 32'h0000_0030);
        @(posedge clk); #1 pix_ready = 1'b1;
        wait_done(60);
        chk("bp_handshakes", 32'(hs_cnt), 32'd16);
        chk("bp_done_count", 32'(done_cnt), 32'd1);
        chk("bp_max_addr", max_addr, 32'd15);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random ready.
        clear_stats();
        ram_base  = 32'h5A5A_0011;
        ram_mul   = 32'h0000_0107;
        pix_ready = 1'b0;
        load_exp();
        pulse_start();
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(posedge clk); #1 pix_ready = 1'($urandom_range(0, 1));
        end
        chk("rnd_done_count", 32'(done_cnt), 32'd1);
        chk("rnd_handshakes", 32'(hs_cnt), 32'd16);
        chk("rnd_scans", 32'(scan_cnt), 32'd1);
        chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

        // Start held high during a scan yields one scan.
        clear_stats();
        ram_base  = 32'h0000_0080;
        ram_mul   = 32'd1;
        pix_ready = 1'b1;
        load_exp();
        @(posedge clk); #1 start = 1'b1;
        repeat (12) @(posedge clk);
        #1 start = 1'b0;
        wait_done(60);
        @(negedge clk);
        chk("hold_scans", 32'(scan_cnt), 32'd1);
        chk("hold_done_count", 32'(done_cnt), 32'd1);
        chk("hold_handshakes", 32'(hs_cnt), 32'd16);

        // Start raised in the done cycle launches a fresh scan.
        clear_stats();
        ram_base = 32'h0000_00C0;
        load_exp();
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (done) begin
                start = 1'b1;
                load_exp();
                break;
            end
        end
        @(posedge clk); #1 start = 1'b0;
        wait_done(60);
        @(negedge clk);
        chk("redo_scans", 32'(scan_cnt), 32'd2);
        chk("redo_done_count", 32'(done_cnt), 32'd2);
        chk("redo_handshakes", 32'(hs_cnt), 32'd32);
        chk("redo_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
